// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate processing element.
// Holds the FSM state encoding and the default operand/accumulator widths.
// Ports: none (package).
package mac_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF  = 24;
    localparam int LEN_WIDTH      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mac_pe_if.sv
// Handshake/data bundle between a MAC processing element and its controller.
// master drives control, length and operands; slave returns ready, chained b, result and status.
// Ports: start, clr, len, in_valid/in_ready, a_in, b_in, b_out, b_valid_out, acc_out, acc_valid, ovf, busy.
interface mac_pe_if
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
);
    logic                  start;
    logic                  clr;
    logic [LEN_WIDTH-1:0]  len;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_in;
    logic [DATA_WIDTH-1:0] b_out;
    logic                  b_valid_out;
    logic [ACC_WIDTH-1:0]  acc_out;
    logic                  acc_valid;
    logic                  ovf;
    logic                  busy;

    modport master (
        output start, clr, len, in_valid, a_in, b_in,
        input  in_ready, b_out, b_valid_out, acc_out, acc_valid, ovf, busy
    );

    modport slave (
        input  start, clr, len, in_valid, a_in, b_in,
        output in_ready, b_out, b_valid_out, acc_out, acc_valid, ovf, busy
    );

endinterface

// File: rtl/mac_sat_add.sv
// Accumulator adder with optional clamp-on-overflow, signed or unsigned.
// Latency: combinational. Backpressure: none.
// Ports: a_dat (accumulator), b_dat (extended product), sum_dat, ovf (overflow of this add).
module mac_sat_add #(
    parameter int ACC_WIDTH = 24,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 1
) (
    input  logic [ACC_WIDTH-1:0] a_dat,
    input  logic [ACC_WIDTH-1:0] b_dat,
    output logic [ACC_WIDTH-1:0] sum_dat,
    output logic                 ovf
);

    localparam int MSB = ACC_WIDTH - 1;

    logic [ACC_WIDTH:0]   raw;
    logic [ACC_WIDTH-1:0] sat_val;

    always_comb begin
        raw     = {1'b0, a_dat} + {1'b0, b_dat};
        ovf     = 1'b0;
        sat_val = '1;
        if (SIGNED != 0) begin
            // Two's complement overflow: like-signed operands give an opposite-signed sum.
            ovf = (a_dat[MSB] == b_dat[MSB]) && (raw[MSB] != a_dat[MSB]);
            // Clamp toward the direction of the incoming term.
            sat_val = b_dat[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            ovf = raw[ACC_WIDTH];
        end
        sum_dat = (ovf && (SATURATE != 0)) ? sat_val : raw[ACC_WIDTH-1:0];
    end

endmodule

// File: rtl/mac_pe.sv
// Two-stage multiply-accumulate processing element computing a len-term dot product.
// Latency: acc_valid 3 cycles after the last accepted term (product reg, add, drain/done).
// Backpressure: in_ready high only in RUN while terms remain; b_out chains accepted b operands.
module mac_pe
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    mac_pe_if.slave  bus
);

    localparam int PW = 2 * DATA_WIDTH;

    mac_state_t            state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic                  prod_vld_q, prod_vld_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  b_vld_q, b_vld_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;

    logic                  in_ready;
    logic                  accept;
    logic                  start_ok;
    logic [PW-1:0]         a_ext, b_ext;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  add_ovf;

    assign in_ready = (state_q == RUN) && (rem_q != '0);
    assign accept   = bus.in_valid && in_ready && !bus.clr;
    assign start_ok = (state_q == IDLE) && bus.start && !bus.clr;

    // Operands are widened to the product width first so the low PW bits of the
    // multiply are correct for both two's complement and unsigned operands.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext    = {{DATA_WIDTH{bus.a_in[DATA_WIDTH-1]}}, bus.a_in};
            b_ext    = {{DATA_WIDTH{bus.b_in[DATA_WIDTH-1]}}, bus.b_in};
            prod_ext = ACC_WIDTH'($signed(prod_q));
        end else begin
            a_ext    = {{DATA_WIDTH{1'b0}}, bus.a_in};
            b_ext    = {{DATA_WIDTH{1'b0}}, bus.b_in};
            prod_ext = ACC_WIDTH'(prod_q);
        end
    end

    mac_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED),
        .SATURATE  (SATURATE)
    ) u_sat_add (
        .a_dat   (acc_q),
        .b_dat   (prod_ext),
        .sum_dat (sum),
        .ovf     (add_ovf)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        b_d        = b_q;
        b_vld_d    = 1'b0;
        acc_d      = acc_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    rem_d   = bus.len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Leave RUN one cycle after the final accept, once its product is
                // being added, so DRAIN/DONE see the complete sum.
                if (rem_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            rem_d      = rem_q - 1'b1;
            prod_d     = a_ext * b_ext;
            prod_vld_d = 1'b1;
            b_d        = bus.b_in;
            b_vld_d    = 1'b1;
        end

        if (prod_vld_q) begin
            acc_d = sum;
            ovf_d = ovf_q | add_ovf;
        end

        if (bus.clr) begin
            state_d    = IDLE;
            rem_d      = '0;
            acc_d      = '0;
            ovf_d      = 1'b0;
            prod_vld_d = 1'b0;
            b_vld_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            b_q        <= '0;
            b_vld_q    <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            b_q        <= b_d;
            b_vld_q    <= b_vld_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.b_out       = b_q;
    assign bus.b_valid_out = b_vld_q;
    assign bus.acc_out     = acc_q;
    assign bus.acc_valid   = (state_q == DONE);
    assign bus.ovf         = ovf_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe: three instances (unsigned/sat 24b, signed/sat 16b, signed/wrap 16b)
// share one stimulus stream; results are compared with an integer reference model.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_mac_pe;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clr   = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] len   = '0;
    logic [7:0]  a_in  = '0;
    logic [7:0]  b_in  = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] op_a [0:511];
    logic [7:0] op_b [0:511];

    always #5 clk = ~clk;

    mac_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(24)) if_u ();
    mac_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) if_s ();
    mac_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) if_w ();

    assign if_u.start = start, if_u.clr = clr, if_u.len = len,
           if_u.in_valid = in_valid, if_u.a_in = a_in, if_u.b_in = b_in;
    assign if_s.start = start, if_s.clr = clr, if_s.len = len,
           if_s.in_valid = in_valid, if_s.a_in = a_in, if_s.b_in = b_in;
    assign if_w.start = start, if_w.clr = clr, if_w.len = len,
           if_w.in_valid = in_valid, if_w.a_in = a_in, if_w.b_in = b_in;

    mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(24), .SIGNED(0), .SATURATE(1))
        u_u (.clk(clk), .rst_n(rst_n), .bus(if_u.slave));
    mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1))
        u_s (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
    mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0))
        u_w (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Dot product of op_a/op_b[0..n-1] in plain integer arithmetic with range clamp/wrap.
    task automatic model(input int n, input bit sgn, input int w, input bit sat,
                         output logic [31:0] res, output bit ov);
        longint acc = 0;
        longint p;
        longint m  = longint'(1) << w;
        longint mx = sgn ? (m / 2 - 1) : (m - 1);
        longint mn = sgn ? -(m / 2) : 0;
        ov = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (sgn) p = longint'($signed(op_a[i])) * longint'($signed(op_b[i]));
            else     p = longint'(op_a[i]) * longint'(op_b[i]);
            acc = acc + p;
            if (acc > mx || acc < mn) begin
                ov = 1'b1;
                if (sat) begin
                    acc = (acc > mx) ? mx : mn;
                end else begin
                    acc = (acc - mn) % m;
                    if (acc < 0) acc = acc + m;
                    acc = acc + mn;
                end
            end
        end
        res = 32'(acc & (m - 1));
    endtask

    // Drives n back-to-back terms from op_a/op_b into a running dot product.
    task automatic feed_n(input int n);
        int got = 0;
        int k   = 0;
        while (got < n && k < 200) begin
            in_valid = 1'b1;
            a_in = op_a[got];
            b_in = op_b[got];
            if (if_u.in_ready) got++;
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        chk("feed_n_count", 32'(got), 32'(n));
    endtask

    // Full dot product of L terms; gap_mode 0 back-to-back, 1 one idle cycle between
    // terms, 2 random gaps. noise pulses start (random len) while RUN, which must be ignored.
    task automatic run_dot(input int L, input int gap_mode, input bit noise);
        int          idx = 0;
        int          wcnt = 0;
        bit          prev_acc = 1'b0;
        bit          give;
        logic [7:0]  prev_b = '0;
        logic [31:0] e_u, e_s, e_w;
        bit          o_u, o_s, o_w;
        model(L, 1'b0, 24, 1'b1, e_u, o_u);
        model(L, 1'b1, 16, 1'b1, e_s, o_s);
        model(L, 1'b1, 16, 1'b0, e_w, o_w);

        start = 1'b1;
        len   = 16'(L);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(if_u.busy), 32'd1);
        for (int k = 0; k < 4000 && idx < L; k++) begin
            chk("b_valid_out", 32'(if_u.b_valid_out), 32'(prev_acc));
            if (prev_acc) chk("b_out", 32'(if_u.b_out), 32'(prev_b));
            start = noise && ($urandom_range(0, 3) == 0);
            len   = 16'($urandom);
            case (gap_mode)
                0:       give = 1'b1;
                1:       give = !prev_acc;
                default: give = ($urandom_range(0, 1) == 1);
            endcase
            in_valid = give;
            a_in     = op_a[idx];
            b_in     = op_b[idx];
            prev_acc = give && if_u.in_ready;
            if (prev_acc) begin
                prev_b = op_b[idx];
                idx++;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (idx < L) chk("feed_timeout", 32'(idx), 32'(L));
        chk("b_valid_out_last", 32'(if_u.b_valid_out), 32'(prev_acc));
        if (prev_acc) chk("b_out_last", 32'(if_u.b_out), 32'(prev_b));
        chk("in_ready_drop", 32'(if_u.in_ready), 32'd0);

        while (!if_u.acc_valid && wcnt < 8) begin
            @(negedge clk);
            wcnt++;
        end
        // Here we are one cycle past the last accept (or start when L=0).
        chk("acc_valid_latency", 32'(wcnt), (L == 0) ? 32'd0 : 32'd2);
        chk("s_acc_valid", 32'(if_s.acc_valid), 32'd1);
        chk("w_acc_valid", 32'(if_w.acc_valid), 32'd1);
        chk("u_acc", 32'(if_u.acc_out), e_u);
        chk("u_ovf", 32'(if_u.ovf), 32'(o_u));
        chk("s_acc", 32'(if_s.acc_out), e_s);
        chk("s_ovf", 32'(if_s.ovf), 32'(o_s));
        chk("w_acc", 32'(if_w.acc_out), e_w);
        chk("w_ovf", 32'(if_w.ovf), 32'(o_w));
        @(negedge clk);
        chk("acc_valid_pulse", 32'(if_u.acc_valid), 32'd0);
        chk("idle_busy", 32'(if_u.busy), 32'd0);
        chk("u_acc_hold", 32'(if_u.acc_out), e_u);
        chk("s_acc_hold", 32'(if_s.acc_out), e_s);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(if_u.in_ready), 32'd0);
        chk("rst_busy", 32'(if_u.busy), 32'd0);
        chk("rst_acc_out", 32'(if_u.acc_out), 32'd0);
        chk("rst_acc_valid", 32'(if_u.acc_valid), 32'd0);
        chk("rst_ovf", 32'(if_u.ovf), 32'd0);
        chk("rst_b_out", 32'(if_u.b_out), 32'd0);
        chk("rst_b_valid_out", 32'(if_u.b_valid_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Small unsigned dot product: 2+12+30+56.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 8'(2 * i + 1);
            op_b[i] = 8'(2 * i + 2);
        end
        run_dot(4, 0, 1'b0);
        chk("dot4_const", 32'(if_u.acc_out), 32'd100);

        // (-128)*(-128) three times: signed overflow, clamp vs wrap.
        for (int i = 0; i < 3; i++) begin
            op_a[i] = 8'h80;
            op_b[i] = 8'h80;
        end
        run_dot(3, 0, 1'b0);
        chk("sat_const", 32'(if_s.acc_out), 32'h7FFF);
        chk("wrap_const", 32'(if_w.acc_out), 32'hC000);
        chk("u_no_ovf_const", 32'(if_u.acc_out), 32'd49152);

        // Zero-length request right after a non-zero result.
        run_dot(0, 0, 1'b0);
        chk("len0_acc", 32'(if_u.acc_out), 32'd0);

        // Five (2,3) terms with one idle cycle between terms.
        for (int i = 0; i < 5; i++) begin
            op_a[i] = 8'd2;
            op_b[i] = 8'd3;
        end
        run_dot(5, 1, 1'b0);
        chk("gap_const", 32'(if_u.acc_out), 32'd30);

        // Abort after two of four terms; clr also outranks in_valid and start.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 8'd3;
            op_b[i] = 8'd5;
        end
        start = 1'b1;
        len   = 16'd4;
        @(negedge clk);
        start = 1'b0;
        feed_n(2);
        clr      = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy", 32'(if_u.busy), 32'd0);
        chk("clr_acc", 32'(if_u.acc_out), 32'd0);
        chk("clr_ovf", 32'(if_u.ovf), 32'd0);
        chk("clr_b_valid", 32'(if_u.b_valid_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("clr_no_valid", 32'(if_u.acc_valid), 32'd0);
            @(negedge clk);
        end
        op_a[0] = 8'd9;
        op_b[0] = 8'd9;
        run_dot(1, 0, 1'b0);
        chk("after_clr_const", 32'(if_u.acc_out), 32'd81);

        // Asynchronous reset in the middle of a run.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 8'd7;
            op_b[i] = 8'd11;
        end
        start = 1'b1;
        len   = 16'd4;
        @(negedge clk);
        start = 1'b0;
        feed_n(2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(if_u.busy), 32'd0);
        chk("mid_rst_acc", 32'(if_u.acc_out), 32'd0);
        chk("mid_rst_b_out", 32'(if_u.b_out), 32'd0);
        chk("mid_rst_in_ready", 32'(if_u.in_ready), 32'd0);
        chk("mid_rst_s_acc", 32'(if_s.acc_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(if_u.acc_valid), 32'd0);
        end

        // Randomised runs with gaps and ignored mid-run start pulses.
        for (int r = 0; r < 24; r++) begin
            int L;
            L = $urandom_range(1, 12);
            for (int i = 0; i < L; i++) begin
                op_a[i] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
                op_b[i] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
            end
            run_dot(L, $urandom_range(0, 2), 1'b1);
        end

        // Unsigned accumulator saturation at 2^24-1 over a long run.
        for (int i = 0; i < 260; i++) begin
            op_a[i] = 8'hFF;
            op_b[i] = 8'hFF;
        end
        run_dot(260, 0, 1'b0);
        chk("u_sat_const", 32'(if_u.acc_out), 32'hFFFFFF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mac_pe.md
MAC_PE -- requirements
Module: mac_pe

Interface
REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the operand width.
REQ-002: Parameter ACC_WIDTH, default 24, SHALL set the accumulator width; ACC_WIDTH >= 2*DATA_WIDTH.
REQ-003: Parameter SIGNED, default 0, SHALL select two's-complement operands (1) or unsigned operands (0).
REQ-004: Parameter SATURATE, default 1, SHALL select clamp-on-overflow (1) or wrap-around (0).
REQ-005: clk  input  1  clock; all logic on the rising edge.
REQ-006: rst_n  input  1  reset, asynchronous, active-low.
REQ-007: start  input  1  one-cycle request to begin a dot product; honoured only in IDLE.
REQ-008: clr  input  1  synchronous abort and clear; valid in any state.
REQ-009: len  input  16  number of terms, sampled on an accepted start.
REQ-010: in_valid  input  1  a_in and b_in carry a term.
REQ-011: in_ready  output  1  block accepts a term this cycle.
REQ-012: a_in, b_in  input  DATA_WIDTH each  operands.
REQ-013: b_out  output  DATA_WIDTH  b_in registered on each accepted term, for systolic chaining.
REQ-014: b_valid_out  output  1  b_out updated this cycle.
REQ-015: acc_out  output  ACC_WIDTH  accumulator value.
REQ-016: acc_valid  output  1  one-cycle pulse: acc_out is final.
REQ-017: ovf  output  1  sticky flag: overflow occurred in the current dot product.
REQ-018: busy  output  1  high in any state other than IDLE.

Function
REQ-019: FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-020: IDLE -> RUN on start when clr=0; the accept event SHALL load the remaining-term count with len and zero acc_out and ovf.
REQ-021: start with len=0 SHALL go IDLE -> DONE, with acc_out=0 and acc_valid asserted in the following cycle.
REQ-022: in_ready SHALL be 1 only in RUN while the remaining count > 0; a term is accepted when in_valid && in_ready.
REQ-023: Stage 1: the product a_in*b_in (2*DATA_WIDTH wide) SHALL be registered on accept, then sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH.
REQ-024: Stage 2: the registered product SHALL be added to the accumulator one cycle after accept.
REQ-025: After the len-th accept, RUN -> DRAIN; DRAIN SHALL last exactly 1 cycle, then -> DONE.
REQ-026: DONE SHALL assert acc_valid for one cycle, then -> IDLE; acc_valid is 3 cycles after the last accept.
REQ-027: acc_out SHALL hold its value in IDLE until the next accepted start or clr.
REQ-028: On overflow with SATURATE=1, the accumulator SHALL clamp to the maximum or minimum of ACC_WIDTH (signed range if SIGNED=1, otherwise 0..2^ACC_WIDTH-1) and stay clamped for further same-direction terms.
REQ-029: On overflow with SATURATE=0, the accumulator SHALL wrap modulo 2^ACC_WIDTH.
REQ-030: In both modes an overflow SHALL set ovf, which stays set until the next accepted start, clr or reset.
REQ-031: start outside IDLE SHALL be ignored.
REQ-032: clr SHALL take priority over start and in_valid.
REQ-033: clr SHALL force IDLE, zero acc_out and ovf, flush stage 1, and suppress acc_valid and b_valid_out in the next cycle.
REQ-034: b_out and b_valid_out SHALL update one cycle after each accepted term; b_out holds otherwise, b_valid_out=0 otherwise.

Reset
REQ-035: rst_n low SHALL asynchronously force state IDLE, zero the remaining count and stage 1, and set every output to 0 (in_ready, b_out, b_valid_out, acc_out, acc_valid, ovf, busy).
REQ-036: Reset asserted mid-dot-product SHALL discard all partial results; no acc_valid is produced.

Structure
REQ-037: Shared package mac_pkg SHALL hold the FSM state enum and the default DATA_WIDTH and ACC_WIDTH constants.
REQ-038: The saturating/wrapping adder SHALL be a sub-module mac_sat_add, parametrised by ACC_WIDTH, SIGNED and SATURATE, with an overflow output.

Verification
REQ-039: Defaults, len=4, terms (1,2),(3,4),(5,6),(7,8) back-to-back -> acc_out=100, acc_valid pulse 3 cycles after the 4th accept, ovf=0.
REQ-040: SIGNED=1, DATA_WIDTH=8, ACC_WIDTH=16, SATURATE=1, len=3, terms (-128,-128)x3 -> acc_out=32767, ovf=1; same run with SATURATE=0 -> acc_out=49152 mod 65536 as signed = -16384, ovf=1.
REQ-041: len=0 start -> acc_valid the next cycle with acc_out=0; in_ready never asserts.
REQ-042: len=5 with in_valid gaps (1 idle cycle between terms), terms (2,3) each -> acc_out=30; in_ready drops after the 5th accept.
REQ-043: clr asserted after 2 of 4 terms -> IDLE next cycle, acc_out=0, no acc_valid; a new start with len=1 and term (9,9) -> acc_out=81.
REQ-044: rst_n pulsed mid-RUN -> all outputs 0 immediately; start asserted during RUN is ignored (the result equals the result without it).
